// File: rtl/load_store_unit.sv
// Load/store unit: a single-outstanding-request bridge between a core and a word-wide memory.
// Sub-word stores use read-modify-write; loads are lane-selected and extended.
module load_store_unit #(
    parameter int unsigned READ_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dataW,
    output logic        MemRW,
    input  logic [31:0] mem_dataB
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WRITE   = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(READ_WAIT - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] addr_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic [31:0] word_q, word_d;
    logic        accept;

    function automatic logic is_illegal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] lane);
        logic ill;
        unique case (f3)
            3'b000:         ill = 1'b0;
            3'b001:         ill = lane[0];
            3'b010:         ill = |lane;
            3'b100, 3'b101: ill = we | (f3[0] & lane[0]);
            default:        ill = 1'b1;
        endcase
        return ill;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        unique case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Only the addressed byte/halfword lanes of the sampled word are replaced.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [1:0] lane);
        logic [31:0] m;
        m = old;
        if (f3[0]) begin
            m[{lane[1], 4'b0000} +: 16] = wd[15:0];
        end else begin
            m[{lane, 3'b000} +: 8] = wd[7:0];
        end
        return m;
    endfunction

    assign accept = req_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                word_d = req_wdata;
                if (req_valid) begin
                    if (is_illegal(req_we, req_funct3, req_addr[1:0])) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else if (req_we && (req_funct3 == 3'b010)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (we_q) begin
                    word_d  = store_merge(mem_dataB, word_q, f3_q, addr_q[1:0]);
                    state_d = WRITE;
                end else begin
                    rdata_d = load_extend(mem_dataB, f3_q, addr_q[1:0]);
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            WRITE: begin
                rdata_d = 32'd0;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response state: cleared asynchronously so MemRW drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request latches and the write word; never observed in IDLE, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= req_addr;
            f3_q   <= req_funct3;
            we_q   <= req_we;
        end
        word_q <= word_d;
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_addr   = (state_q == IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};
    assign MemRW      = (state_q == WRITE);
    assign mem_dataW  = (state_q == WRITE) ? word_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory and hand-computed expectations.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_dataW;
    logic        MemRW;
    logic [31:0] mem_dataB;

    logic [31:0] mem [0:255];
    logic        pl;
    logic [31:0] last_wa, last_wd;
    int          wr_cnt, rv_cnt, acc_cnt, cyc, last_rv_cyc, prev_rv_cyc;
    int          total, bad;
    int          lat, wr0, rv0, acc0;

    load_store_unit #(.READ_WAIT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_dataW  (mem_dataW),
        .MemRW      (MemRW),
        .mem_dataB  (mem_dataB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_dataB = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl) begin
            mem[64] <= 32'h8899AABB;
        end else if (MemRW) begin
            mem[mem_addr[9:2]] <= mem_dataW;
            last_wa <= mem_addr;
            last_wd <= mem_dataW;
            wr_cnt  <= wr_cnt + 1;
        end
        if (resp_valid) begin
            rv_cnt      <= rv_cnt + 1;
            prev_rv_cyc <= last_rv_cyc;
            last_rv_cyc <= cyc;
        end
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int l);
        @(negedge clk);
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        l = 1;
        while (!resp_valid && l < 30) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        total = 0; bad = 0;
        cyc = 0; wr_cnt = 0; rv_cnt = 0; acc_cnt = 0; last_rv_cyc = 0; prev_rv_cyc = 0;
        last_wa = 32'd0; last_wd = 32'd0;
        rst_n = 1'b0; pl = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_dataW", mem_dataW, 32'd0);
        chk("rst_memrw", 32'(MemRW), 32'd0);
        repeat (3) @(negedge clk);
        pl = 1'b0;
        rst_n = 1'b1;

        do_req(1'b0, 3'b000, 32'h103, 32'd0, lat);
        chk("lb_lat", 32'(lat), 32'd2);
        chk("lb_data", resp_rdata, 32'hFFFFFF88);
        chk("lb_err", 32'(resp_err), 32'd0);
        do_req(1'b0, 3'b100, 32'h103, 32'd0, lat);
        chk("lbu_data", resp_rdata, 32'h00000088);
        do_req(1'b0, 3'b001, 32'h102, 32'd0, lat);
        chk("lh_data", resp_rdata, 32'hFFFF8899);
        do_req(1'b0, 3'b101, 32'h100, 32'd0, lat);
        chk("lhu_data", resp_rdata, 32'h0000AABB);
        repeat (2) @(negedge clk);
        chk("hold_rdata", resp_rdata, 32'h0000AABB);
        chk("hold_valid_low", 32'(resp_valid), 32'd0);

        wr0 = wr_cnt;
        do_req(1'b1, 3'b001, 32'h102, 32'h00001234, lat);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_writes", 32'(wr_cnt - wr0), 32'd1);
        chk("sh_addr", last_wa, 32'h100);
        chk("sh_data", last_wd, 32'h1234AABB);
        chk("sh_mem", mem[64], 32'h1234AABB);

        do_req(1'b1, 3'b000, 32'h101, 32'hFFFFFF55, lat);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_mem", mem[64], 32'h123455BB);

        wr0 = wr_cnt;
        do_req(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, lat);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_writes", 32'(wr_cnt - wr0), 32'd1);
        chk("sw_addr", last_wa, 32'h20);
        do_req(1'b0, 3'b010, 32'h20, 32'd0, lat);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_data", resp_rdata, 32'hDEADBEEF);

        wr0 = wr_cnt;
        do_req(1'b0, 3'b010, 32'h22, 32'd0, lat);
        chk("mis_lw_lat", 32'(lat), 32'd1);
        chk("mis_lw_err", 32'(resp_err), 32'd1);
        chk("mis_lw_rdata", resp_rdata, 32'd0);
        do_req(1'b1, 3'b100, 32'h20, 32'h77, lat);
        chk("sbu_err", 32'(resp_err), 32'd1);
        chk("sbu_lat", 32'(lat), 32'd1);
        do_req(1'b0, 3'b011, 32'h20, 32'd0, lat);
        chk("f3_011_err", 32'(resp_err), 32'd1);
        do_req(1'b1, 3'b001, 32'h21, 32'h99, lat);
        chk("mis_sh_err", 32'(resp_err), 32'd1);
        chk("err_no_writes", 32'(wr_cnt - wr0), 32'd0);
        do_req(1'b0, 3'b000, 32'h21, 32'd0, lat);
        chk("err_cleared", 32'(resp_err), 32'd0);
        chk("lb_after_err", resp_rdata, 32'hFFFFFFBE);

        // Reset while an SB sits in WRITE.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h11;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_in_write", 32'(MemRW), 32'd1);
        wr0 = wr_cnt; rv0 = rv_cnt;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_drops_memrw", 32'(MemRW), 32'd0);
        chk("rst_drops_addr", mem_addr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_mem_unchanged", mem[8], 32'hDEADBEEF);
        chk("rst_no_write", 32'(wr_cnt - wr0), 32'd0);
        chk("rst_no_resp", 32'(rv_cnt - rv0), 32'd0);
        chk("rst_ready_after", 32'(req_ready), 32'd1);

        // req_valid held high: one SW every 3 cycles.
        wr0 = wr_cnt; rv0 = rv_cnt; acc0 = acc_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hA5A50001;
        repeat (9) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_cnt - acc0), 32'd3);
        chk("b2b_writes", 32'(wr_cnt - wr0), 32'd3);
        chk("b2b_resps", 32'(rv_cnt - rv0), 32'd3);
        chk("b2b_period", 32'(last_rv_cyc - prev_rv_cyc), 32'd3);
        chk("b2b_mem", mem[16], 32'hA5A50001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
